// File: rtl/carlosgs99_pkg.sv
// Shared definitions for the carlosgs99 arithmetic tile: divider FSM state codes,
// default operand width and iteration-counter sizing.
package carlosgs99_pkg;

  localparam int BITS = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // The counter must be able to count the 2*bits iterations.
  function automatic int cnt_width(input int b);
    return $clog2(2 * b + 1);
  endfunction

endpackage

// File: rtl/tt_um_carlosgs99_div_4bits_if.sv
// Start/ready/done handshake and operand/result bus of the sequential divider.
interface tt_um_carlosgs99_div_4bits_if #(
  parameter int bits = 4
);

  logic                start;
  logic [2*bits-1:0]   dividend;
  logic [bits-1:0]     divisor;
  logic                ready;
  logic                done;
  logic                div0;
  logic [2*bits-1:0]   quotient;
  logic [bits-1:0]     remainder;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  ready,
    input  done,
    input  div0,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output ready,
    output done,
    output div0,
    output quotient,
    output remainder
  );

endinterface

// File: rtl/tt_um_carlosgs99_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module tt_um_carlosgs99_div_step
  import carlosgs99_pkg::*;
#(
  parameter int bits = BITS
) (
  input  logic [bits-1:0] rem,
  input  logic            dvd_msb,
  input  logic [bits-1:0] divisor,
  output logic [bits-1:0] rem_next,
  output logic            qbit
);

  logic        [bits:0] shifted;
  logic signed [bits:0] trial;

  // The partial remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the top bit of the difference is a clean borrow.
  always_comb begin
    shifted  = {rem, dvd_msb};
    trial    = $signed(shifted - {1'b0, divisor});
    qbit     = ~trial[bits];
    rem_next = qbit ? trial[bits-1:0] : shifted[bits-1:0];
  end

endmodule

// File: rtl/tt_um_carlosgs99_div_4bits.sv
// Sequential unsigned restoring divider: 2*bits-wide dividend by bits-wide divisor,
// one quotient bit per clock, start/ready/done handshake.
module tt_um_carlosgs99_div_4bits
  import carlosgs99_pkg::*;
#(
  parameter int bits = BITS
) (
  input  logic                         io_clk,
  input  logic                         io_rst_n,
  tt_um_carlosgs99_div_4bits_if.slave  bus
);

  localparam int CNT_W = cnt_width(bits);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * bits - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               accept;
  logic               zero_div;

  logic [2*bits-1:0]  dvd;
  logic [bits-1:0]    dsr;
  logic [bits-1:0]    rem;
  logic [2*bits-2:0]  quo;

  logic [bits-1:0]    rem_next;
  logic               qbit;

  logic               ready;
  logic               done;
  logic [2*bits-1:0]  quotient;
  logic [bits-1:0]    remainder;
  logic               div0;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign zero_div = (bus.divisor == '0);
  assign last     = (cnt == LAST);

  tt_um_carlosgs99_div_step #(
    .bits (bits)
  ) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[2*bits-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = zero_div ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_DONE: done  = 1'b1;
      default: begin
        ready = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      cnt <= '0;
    end else if (state == ST_BUSY) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Working registers carry no reset: they are always reloaded on an accepted start.
  always_ff @(posedge io_clk) begin
    if (accept) begin
      dvd <= bus.dividend;
      dsr <= bus.divisor;
      rem <= '0;
      quo <= '0;
    end else if (state == ST_BUSY) begin
      dvd <= {dvd[2*bits-2:0], 1'b0};
      rem <= rem_next;
      quo <= {quo[2*bits-3:0], qbit};
    end
  end

  // Results are published only on completion and hold until the next one.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else if (accept && zero_div) begin
      quotient  <= '1;
      remainder <= '0;
      div0      <= 1'b1;
    end else if ((state == ST_BUSY) && last) begin
      quotient  <= {quo, qbit};
      remainder <= rem_next;
      div0      <= 1'b0;
    end
  end

  assign bus.ready     = ready;
  assign bus.done      = done;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.div0      = div0;

endmodule

// File: tb/tb_tt_um_carlosgs99_div_4bits.sv
// Directed and exhaustive bench for the 4-bit sequential restoring divider.
module tb_tt_um_carlosgs99_div_4bits;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tt_um_carlosgs99_div_4bits_if #(.bits(4)) bus ();

  tt_um_carlosgs99_div_4bits #(.bits(4)) dut (
    .io_clk   (clk),
    .io_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input int a, input int b, input string tag);
    int n;
    int eq;
    int er;
    n = 0;
    while (!bus.ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, int'(bus.ready), 1);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 4'(b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    eq = (b == 0) ? 255 : a / b;
    er = (b == 0) ? 0 : a % b;
    check({tag, "_latency"}, n, (b == 0) ? 0 : 8);
    check({tag, "_q"}, int'(bus.quotient), eq);
    check({tag, "_r"}, int'(bus.remainder), er);
    check({tag, "_div0"}, int'(bus.div0), (b == 0) ? 1 : 0);
    if (b != 0) begin
      check({tag, "_invariant"}, int'(bus.quotient) * b + int'(bus.remainder), a);
      check({tag, "_r_lt_d"}, int'(int'(bus.remainder) < b), 1);
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_q", int'(bus.quotient), 0);
    check("rst_r", int'(bus.remainder), 0);
    check("rst_div0", int'(bus.div0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(200, 13, "d200_13");
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", int'(bus.quotient), 15);
    check("hold_r", int'(bus.remainder), 5);
    run_op(255, 1, "d255_1");
    run_op(7, 9, "d7_9");
    run_op(0, 5, "d0_5");
    run_op(100, 0, "d100_0");
    run_op(100, 10, "d100_10");

    // start pulses with other operands during BUSY (cycle 3) and DONE (cycle 9)
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_hold_q", int'(bus.quotient), 10);
    check("busy_ready", int'(bus.ready), 0);
    repeat (5) @(posedge clk);
    #1;
    check("ign_done", int'(bus.done), 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ign_ready", int'(bus.ready), 1);
    check("ign_q", int'(bus.quotient), 15);
    check("ign_r", int'(bus.remainder), 5);
    @(posedge clk); #1;
    check("ign_still_idle", int'(bus.ready), 1);

    // asynchronous reset in the middle of an operation
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", int'(bus.quotient), 0);
    check("mid_rst_r", int'(bus.remainder), 0);
    check("mid_rst_div0", int'(bus.div0), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_ready", int'(bus.ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_q", int'(bus.quotient), 0);
    run_op(143, 11, "d143_11");

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, "exh");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
